// File: rtl/s5_inv_stream.sv
// Streaming inverse of the S5 5-to-4 S-box with a 2-entry output FIFO and transfer counter.
// Optional forward re-check of every output is enabled by defining S5_INV_SELFCHECK_EN.
module s5_inv_stream #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             IN_SEL,
  input  logic [3:0]       D_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [4:0]       D_OUT,
  input  logic             CLR_CNT,
  output logic [CNT_W-1:0] SYM_CNT,
  output logic             SELF_ERR
);

  // Inverse tables, entry 0 in the least significant nibble.
  localparam logic [63:0] INV0 = {4'd7, 4'd15, 4'd4, 4'd5, 4'd3, 4'd9, 4'd0, 4'd14,
                                  4'd12, 4'd11, 4'd13, 4'd2, 4'd6, 4'd10, 4'd8, 4'd1};
  localparam logic [63:0] INV1 = {4'd8, 4'd14, 4'd3, 4'd1, 4'd12, 4'd13, 4'd7, 4'd15,
                                  4'd5, 4'd2, 4'd4, 4'd11, 4'd0, 4'd9, 4'd6, 4'd10};

  function automatic logic [3:0] inv_lut(input logic sel, input logic [3:0] d);
    logic [5:0] idx;
    idx = {d, 2'b00};
    return sel ? INV1[idx +: 4] : INV0[idx +: 4];
  endfunction

  logic [1:0]       cnt_q, cnt_d, lvl;
  logic             rdy_q, rdy_d;
  logic [4:0]       e0_q, e0_d, e1_q, e1_d;
  logic [CNT_W-1:0] sym_q, sym_d;
  logic             push, pop;
  logic [4:0]       new_ent;

  assign new_ent   = {IN_SEL, inv_lut(IN_SEL, D_IN)};
  assign pop       = (cnt_q != 2'd0) && OUT_READY;
  assign push      = IN_VALID && rdy_q;
  assign lvl       = cnt_q - {1'b0, pop};
  assign IN_READY  = rdy_q;
  assign OUT_VALID = (cnt_q != 2'd0);
  assign D_OUT     = e0_q;
  assign SYM_CNT   = sym_q;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop && cnt_q == 2'd2) e0_d = e1_q;
    if (push) begin
      if (lvl == 2'd0) e0_d = new_ent;
      else             e1_d = new_ent;
    end
    cnt_d = lvl + {1'b0, push};
    // Ready is precomputed for the next cycle so it never depends on OUT_READY.
    rdy_d = (cnt_d < 2'd2);
    if (CLR_CNT)  sym_d = '0;
    else if (pop) sym_d = sym_q + 1'b1;
    else          sym_d = sym_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
      e0_q  <= '0;
      e1_q  <= '0;
      sym_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      sym_q <= sym_d;
    end
  end

`ifdef S5_INV_SELFCHECK_EN
  logic [3:0] n0_q, n0_d, n1_q, n1_d;
  logic       err_q, err_d;

  // Forward S5 recovered by searching the inverse table for the matching nibble.
  function automatic logic [3:0] fwd_lut(input logic sel, input logic [3:0] j);
    logic [3:0] f;
    f = 4'd0;
    for (int k = 0; k < 16; k++)
      if (inv_lut(sel, 4'(k)) == j) f = 4'(k);
    return f;
  endfunction

  always_comb begin
    n0_d = n0_q;
    n1_d = n1_q;
    if (pop && cnt_q == 2'd2) n0_d = n1_q;
    if (push) begin
      if (lvl == 2'd0) n0_d = D_IN;
      else             n1_d = D_IN;
    end
    err_d = err_q | (pop && (fwd_lut(e0_q[4], e0_q[3:0]) != n0_q));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n0_q  <= '0;
      n1_q  <= '0;
      err_q <= 1'b0;
    end else begin
      n0_q  <= n0_d;
      n1_q  <= n1_d;
      err_q <= err_d;
    end
  end

  assign SELF_ERR = err_q;
`else
  assign SELF_ERR = 1'b0;
`endif

endmodule

// File: doc/s5_inv_stream.md
Name: s5_inv_stream

Overview:
- Streaming inverse of the 5-to-4 S5 post-processing S-box. Each half of the forward table (D_IN[4]=0 and D_IN[4]=1) is a 4-bit permutation.
- Given a 4-bit S5 output nibble plus the half-select bit, the block recovers the unique 5-bit S5 input.
- Sits on the post-processing verification path. It reconstructs pre-S-box words from logged nibbles, with a valid/ready handshake, a 2-entry output buffer and a transfer counter.

Parameters:
- CNT_W, 16, width of the output-transfer counter SYM_CNT.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  input symbol valid.
- IN_READY  output  1  block can accept a symbol this cycle.
- IN_SEL  input  1  half select (the forward D_IN[4]).
- D_IN  input  4  S5 output nibble to invert.
- OUT_VALID  output  1  D_OUT holds a valid result.
- OUT_READY  input  1  downstream accepts D_OUT.
- D_OUT  output  5  recovered S5 input, {IN_SEL, j}.
- CLR_CNT  input  1  synchronous clear of SYM_CNT.
- SYM_CNT  output  CNT_W  count of completed output transfers.
- SELF_ERR  output  1  sticky self-check error; constant 0 when the optional feature is off.

Behaviour:
- Reset (RST_N low, asynchronous): FIFO empty, OUT_VALID=0, D_OUT=0, IN_READY=0 while RST_N is low, SYM_CNT=0, SELF_ERR=0.
- IN_READY = (fifo_count < 2). It is driven from registers only, with no combinational path from OUT_READY.
- Input accept: IN_VALID && IN_READY at a rising edge. The lookup is combinational and the result is written into the 2-entry FIFO at that edge.
- Latency: an accepted symbol appears on D_OUT with OUT_VALID=1 on the next cycle when the FIFO was empty. Otherwise it follows queued entries in strict order.
- Output transfer: OUT_VALID && OUT_READY pops the head. D_OUT and OUT_VALID are registered and stable while OUT_VALID=1 && OUT_READY=0.
- Push and pop in the same cycle:
  - count 1: count stays 1 and the new entry becomes the head.
  - count 2: no push is possible (IN_READY=0), so the pop yields count 1.
- Throughput: 1 symbol/cycle sustained while OUT_READY stays high.
- Inverse table for IN_SEL=0, D_IN 0..15 -> j: 1,8,10,6,2,13,11,12,14,0,9,3,5,4,15,7.
- Inverse table for IN_SEL=1, D_IN 0..15 -> j: 10,6,9,0,11,4,2,5,15,7,13,12,1,3,14,8.
- D_OUT = {IN_SEL, j}, i.e. j or 16+j.
- SYM_CNT: increments by 1 per output transfer and wraps modulo 2^CNT_W. CLR_CNT forces 0 at the next edge and takes priority over a simultaneous transfer.
- States: only the FIFO count (0/1/2); no other FSM.

Optional Feature:
- Macro: S5_INV_SELFCHECK_EN.
- Defined:
  - each FIFO entry also stores the original 4-bit D_IN;
  - at every output transfer the forward S5 of D_OUT is computed and compared with the stored nibble;
  - a mismatch sets SELF_ERR=1, which stays set until RST_N;
  - CLR_CNT does not clear SELF_ERR.
- Undefined: no stored nibble, no forward table, and SELF_ERR tied to 0.

Test Plan:
- Table sweep: after reset, OUT_READY=1, apply IN_SEL=0 D_IN=0 then IN_SEL=1 D_IN=0, IN_SEL=0 D_IN=15, IN_SEL=1 D_IN=15 on consecutive cycles -> D_OUT=1, 26, 7, 24 on consecutive cycles, each one cycle after accept. Then sweep all 32 inputs against both tables.
- Backpressure: OUT_READY=0, IN_VALID=1 for 3 cycles with D_IN=3,4,5 and IN_SEL=0 -> IN_READY drops after 2 accepts, D_OUT holds 6. Raise OUT_READY -> outputs 6 then 2, the third symbol is accepted one cycle after the first pop, then yields 13.
- Counter: CNT_W=4, 17 output transfers -> SYM_CNT=1. CLR_CNT asserted in the same cycle as a transfer -> SYM_CNT=0 next cycle.
- Reset mid-operation: 2 entries queued, pull RST_N low between edges -> OUT_VALID=0, SYM_CNT=0 immediately. After release, the first new symbol (IN_SEL=1, D_IN=12) -> D_OUT=17.
- Self-check (S5_INV_SELFCHECK_EN defined): full 32-entry sweep -> SELF_ERR stays 0. Force the stored nibble to mismatch via a bench override -> SELF_ERR=1, still 1 after CLR_CNT, cleared only by RST_N.
